// File: rtl/zeroriscy_md_seq.sv
// Sequential multiply/divide unit that borrows the core's shared ALU adder for every add/subtract.
// Latency: MULL/MULH ready_o 33 cycles after accept; DIV/REM 36 (1 for divide-by-zero when shortcut enabled).
// Backpressure: requester holds en_i until the ready_o pulse; en_i is only sampled in IDLE.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   en_i, operator_i, signed_mode_i  request; operator 00 MULL, 01 MULH, 10 DIV, 11 REM;
//                                    signed_mode bit0 = op_a signed, bit1 = op_b signed
//   op_a_i, op_b_i                   operands, latched at accept
//   alu_operand_a/b_o, alu_en_o      shared adder request; operands are {value, carry_in}
//   alu_adder_ext_i                  shared adder extended sum; [32:1] = sum, [33] = carry out
//   busy_o, ready_o, result_o        status and result (result held until the next accept)
//
// Build option: define ZERORISCY_MD_DIVZERO_SHORTCUT_EN to finish DIV/REM by zero in one cycle
// without touching the shared adder.

module zeroriscy_md_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [1:0]  operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [33:0] alu_adder_ext_i,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    output logic        alu_en_o,
    output logic        busy_o,
    output logic        ready_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] OP_DIV = 2'b10;

    typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, COMP, CHG_SIGN, FINISH} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] acc_q;     // MUL: high product word; DIV: partial remainder
    logic [31:0] lo_q;      // MUL: multiplier shifting out / low product; DIV: dividend shifting out / quotient
    logic [31:0] a_q;       // MUL: multiplicand; DIV: divisor (made absolute in ABS_B)
    logic [1:0]  op_q;
    logic        sa_q, sb_q, a_neg_q, b_neg_q, b_zero_q;

    logic [31:0] add_a, add_b;
    logic        add_cin;
    logic [31:0] alu_sum;
    logic        alu_cout;
    logic        alu_ext_unused;

    logic        div_shortcut;
    logic        mul_bit, mul_sub, mul_xa, mul_xb, mul_top;
    logic [31:0] div_rem_sh;
    logic        div_ge, q_neg;

`ifdef ZERORISCY_MD_DIVZERO_SHORTCUT_EN
    assign div_shortcut = operator_i[1] & (op_b_i == 32'd0);
`else
    assign div_shortcut = 1'b0;
`endif

    assign alu_sum        = alu_adder_ext_i[32:1];
    assign alu_cout       = alu_adder_ext_i[33];
    assign alu_ext_unused = alu_adder_ext_i[0];

    // Shift-add multiply: the last multiplier bit carries weight -2^31 when op_b is signed,
    // so that step subtracts. The 33rd sum bit is rebuilt from the operands' extension bits.
    assign mul_bit = lo_q[0];
    assign mul_sub = sb_q & (cnt_q == 5'd31);
    assign mul_xa  = sa_q & acc_q[31];
    assign mul_xb  = mul_bit & ((sa_q & a_q[31]) ^ mul_sub);
    assign mul_top = mul_xa ^ mul_xb ^ alu_cout;

    // Restoring divide: the shifted remainder is 33 bits wide; its top bit or the adder's
    // carry-out both mean "remainder >= divisor".
    assign div_rem_sh = {acc_q[30:0], lo_q[31]};
    assign div_ge     = acc_q[31] | alu_cout;
    // Division by zero must keep the all-ones quotient, so it is never negated.
    assign q_neg      = (a_neg_q ^ b_neg_q) & ~b_zero_q;

    assign result_o = op_q[0] ? acc_q : lo_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    if (div_shortcut)       state_d = FINISH;
                    else if (operator_i[1]) state_d = ABS_A;
                    else                    state_d = COMP;
                end
            end
            ABS_A:    state_d = ABS_B;
            ABS_B:    state_d = COMP;
            COMP:     if (cnt_q == 5'd31) state_d = op_q[1] ? CHG_SIGN : FINISH;
            CHG_SIGN: state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs and shared adder operand selection
    always_comb begin
        busy_o   = (state_q != IDLE);
        ready_o  = (state_q == FINISH);
        alu_en_o = 1'b0;
        add_a    = 32'd0;
        add_b    = 32'd0;
        add_cin  = 1'b0;
        case (state_q)
            ABS_A: begin
                alu_en_o = 1'b1;
                add_b    = a_neg_q ? ~lo_q : lo_q;
                add_cin  = a_neg_q;
            end
            ABS_B: begin
                alu_en_o = 1'b1;
                add_b    = b_neg_q ? ~a_q : a_q;
                add_cin  = b_neg_q;
            end
            COMP: begin
                alu_en_o = 1'b1;
                if (op_q[1]) begin
                    add_a   = div_rem_sh;
                    add_b   = ~a_q;
                    add_cin = 1'b1;
                end else begin
                    add_a   = acc_q;
                    add_b   = mul_bit ? (mul_sub ? ~a_q : a_q) : 32'd0;
                    add_cin = mul_bit & mul_sub;
                end
            end
            CHG_SIGN: begin
                alu_en_o = 1'b1;
                if (op_q == OP_DIV) begin
                    add_b   = q_neg ? ~lo_q : lo_q;
                    add_cin = q_neg;
                end else begin
                    add_b   = a_neg_q ? ~acc_q : acc_q;
                    add_cin = a_neg_q;
                end
            end
            default: ;
        endcase
        alu_operand_a_o = alu_en_o ? {add_a, add_cin} : 33'd0;
        alu_operand_b_o = alu_en_o ? {add_b, add_cin} : 33'd0;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= 5'd0;
            acc_q    <= 32'd0;
            lo_q     <= 32'd0;
            a_q      <= 32'd0;
            op_q     <= 2'b00;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        op_q     <= operator_i;
                        sa_q     <= signed_mode_i[0];
                        sb_q     <= signed_mode_i[1];
                        a_neg_q  <= signed_mode_i[0] & op_a_i[31];
                        b_neg_q  <= signed_mode_i[1] & op_b_i[31];
                        b_zero_q <= (op_b_i == 32'd0);
                        cnt_q    <= 5'd0;
                        if (div_shortcut) begin
                            acc_q <= op_a_i;
                            lo_q  <= 32'hFFFF_FFFF;
                            a_q   <= op_b_i;
                        end else if (operator_i[1]) begin
                            acc_q <= 32'd0;
                            lo_q  <= op_a_i;
                            a_q   <= op_b_i;
                        end else begin
                            acc_q <= 32'd0;
                            lo_q  <= op_b_i;
                            a_q   <= op_a_i;
                        end
                    end
                end
                ABS_A: lo_q <= alu_sum;
                ABS_B: a_q  <= alu_sum;
                COMP: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (op_q[1]) begin
                        acc_q <= div_ge ? alu_sum : div_rem_sh;
                        lo_q  <= {lo_q[30:0], div_ge};
                    end else begin
                        acc_q <= {mul_top, alu_sum[31:1]};
                        lo_q  <= {alu_sum[0], lo_q[31:1]};
                    end
                end
                CHG_SIGN: begin
                    if (op_q == OP_DIV) lo_q  <= alu_sum;
                    else                acc_q <= alu_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zeroriscy_md_seq.sv
module tb_zeroriscy_md_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic [1:0]  operator_i;
    logic [1:0]  signed_mode_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [33:0] alu_adder_ext_i;
    logic [32:0] alu_operand_a_o;
    logic [32:0] alu_operand_b_o;
    logic        alu_en_o;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;

    zeroriscy_md_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_i            (en_i),
        .operator_i      (operator_i),
        .signed_mode_i   (signed_mode_i),
        .op_a_i          (op_a_i),
        .op_b_i          (op_b_i),
        .alu_adder_ext_i (alu_adder_ext_i),
        .alu_operand_a_o (alu_operand_a_o),
        .alu_operand_b_o (alu_operand_b_o),
        .alu_en_o        (alu_en_o),
        .busy_o          (busy_o),
        .ready_o         (ready_o),
        .result_o        (result_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU: plain 33-bit adder while claimed, unrelated noise otherwise.
    logic [33:0] junk = 34'd0;
    always @(negedge clk) begin
        logic [31:0] r;
        r = $urandom;
        junk <= {r[1:0], $urandom};
    end
    assign alu_adder_ext_i = alu_en_o ? ({1'b0, alu_operand_a_o} + {1'b0, alu_operand_b_o}) : junk;

    typedef struct {
        logic [31:0] res;
        int          c0;
        int          lat;
        logic [1:0]  op;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    bit   at_finish = 1'b0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operands as the signed mode reads them.
    function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
        longint x, y, p, q, r;
        logic [31:0] res;
        x = sm[0] ? longint'($signed(a)) : longint'(a);
        y = sm[1] ? longint'($signed(b)) : longint'(b);
        p = x * y;
        res = 32'd0;
        case (op)
            2'b00: res = p[31:0];
            2'b01: res = p[63:32];
            default: begin
                if (b == 32'd0) begin
                    res = (op == 2'b10) ? 32'hFFFF_FFFF : a;
                end else begin
                    q = x / y;
                    r = x % y;
                    res = (op == 2'b10) ? q[31:0] : r[31:0];
                end
            end
        endcase
        return res;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return 33;
`ifdef ZERORISCY_MD_DIVZERO_SHORTCUT_EN
        if (b == 32'd0) return 1;
`endif
        return 36;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(7, 0))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = $urandom_range(15, 0);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        en_i  = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        at_finish = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            at_finish = 1'b1;
        end else begin
            total++;
            bad++;
            $display("FAIL ready_timeout actual=no_ready expected=ready_within_64");
            do_reset();
        end
    endtask

    // Issue one operation; b2b keeps en_i high straight out of the previous FINISH cycle.
    task automatic do_op(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input bit b2b);
        exp_t e;
        int c0;
        if (at_finish && b2b) begin
            c0 = cyc + 1;
        end else begin
            if (at_finish) begin
                en_i = 1'b0;
                @(posedge clk);
                #1;
            end
            chk("idle_busy", {32'd0, busy_o}, 33'd0);
            c0 = cyc;
        end
        en_i          = 1'b1;
        operator_i    = op;
        signed_mode_i = sm;
        op_a_i        = a;
        op_b_i        = b;
        e.res = exp_res;
        e.c0  = c0;
        e.lat = ref_lat(op, b);
        e.op  = op;
        sb_q.push_back(e);
        wait_done();
    endtask

    // Monitor: pops the scoreboard whenever ready_o is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!alu_en_o) begin
                chk("opnd_a_idle", alu_operand_a_o, 33'd0);
                chk("opnd_b_idle", alu_operand_b_o, 33'd0);
            end
            if (ready_o) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready actual=ready expected=no_ready");
                end else begin
                    mon_e = sb_q.pop_front();
                    chk($sformatf("result_op%0d", mon_e.op), {1'b0, result_o}, {1'b0, mon_e.res});
                    chk($sformatf("latency_op%0d", mon_e.op), {1'b0, cyc - mon_e.c0}, {1'b0, mon_e.lat});
                    chk("busy_at_ready", {32'd0, busy_o}, 33'd1);
                    chk("alu_en_at_ready", {32'd0, alu_en_o}, 33'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        en_i          = 1'b0;
        operator_i    = 2'b00;
        signed_mode_i = 2'b00;
        op_a_i        = 32'd0;
        op_b_i        = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {32'd0, busy_o},   33'd0);
        chk("rst_ready",  {32'd0, ready_o},  33'd0);
        chk("rst_alu_en", {32'd0, alu_en_o}, 33'd0);
        chk("rst_opnd_a", alu_operand_a_o,   33'd0);
        chk("rst_opnd_b", alu_operand_b_o,   33'd0);
        chk("rst_result", {1'b0, result_o},  33'd0);
        rst_n = 1'b1;

        // Directed cases with hand-derived results.
        do_op(2'b00, 2'b11, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        do_op(2'b01, 2'b11, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
        do_op(2'b01, 2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        do_op(2'b10, 2'b11, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        do_op(2'b11, 2'b11, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b1);
        do_op(2'b10, 2'b00, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0);
        do_op(2'b11, 2'b00, 32'd5,          32'd0,         32'd5,         1'b0);
        do_op(2'b10, 2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        do_op(2'b11, 2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0);
        do_op(2'b10, 2'b11, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b0);
        do_op(2'b11, 2'b11, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1);
        do_op(2'b01, 2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Reset in the middle of a DIV, then a fresh MULL.
        if (at_finish) begin
            en_i = 1'b0;
            @(posedge clk);
            #1;
        end
        en_i          = 1'b1;
        operator_i    = 2'b10;
        signed_mode_i = 2'b11;
        op_a_i        = 32'd100;
        op_b_i        = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        en_i  = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy",   {32'd0, busy_o},   33'd0);
        chk("abort_alu_en", {32'd0, alu_en_o}, 33'd0);
        chk("abort_ready",  {32'd0, ready_o},  33'd0);
        rst_n = 1'b1;
        at_finish = 1'b0;
        do_op(2'b00, 2'b00, 32'd3, 32'd4, 32'd12, 1'b0);

        // Randomized operations against the reference model.
        for (int k = 0; k < 48; k++) begin
            logic [1:0]  op, sm;
            logic [31:0] a, b;
            op = 2'($urandom_range(3, 0));
            sm = 2'($urandom_range(3, 0));
            a  = pick();
            b  = pick();
            do_op(op, sm, a, b, ref_md(op, sm, a, b), 1'($urandom_range(1, 0)));
        end

        en_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", {1'b0, 32'(sb_q.size())}, 33'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
